// File: rtl/gf2_poly_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : gf2_poly_divider_if
//  Description : Handshake and operand/result bundle of the GF(2)[x]
//                polynomial divider. The master side issues start with the
//                operands. The slave side returns status and results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface gf2_poly_divider_if #(
  parameter int N = 571
);
  logic             start;
  logic [2*N-1:0]   dividend;
  logic [N:0]       divisor;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [2*N-1:0]   quotient;
  logic [N-1:0]     remainder;

  modport master (
    output start, dividend, divisor,
    input  busy, done, div_by_zero, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, div_by_zero, quotient, remainder
  );
endinterface
`default_nettype wire

// File: rtl/gf2_poly_divider.sv
`default_nettype none
// ============================================================================
//  Module      : gf2_poly_divider
//  Description : Bit-serial GF(2)[x] long divider. Consumes one dividend bit
//                per cycle, MSB first, and returns the quotient and remainder
//                2N cycles after the accepting edge. A zero divisor is flagged
//                and answered in one cycle.
//  Options     : GF2_DIV_QUOTIENT_EN - when defined, the quotient register is
//                built and drives the quotient port. When undefined, the
//                divider runs in reduction-only mode and quotient is tied to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf2_poly_divider #(
  parameter int N = 571
) (
  input  logic              clk,
  input  logic              rst,
  gf2_poly_divider_if.slave bus
);

  localparam int             c_DEG_W  = $clog2(N + 1);
  localparam int             c_K_W    = $clog2(2 * N + 1);
  localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(2 * N - 1);

  localparam logic [0:0] c_IDLE = 1'b0;
  localparam logic [0:0] c_DIV  = 1'b1;

  logic [0:0]         r_state;
  logic [0:0]         w_state_next;

  // D shifts out dividend bits at the top. Quotient bits enter at the bottom,
  // so after 2N steps D holds the complete quotient.
  logic [2*N-1:0]     r_d;
  // Only bits below the divisor degree can be set between steps, so R[N] is
  // always zero once stored. The top bit exists only in the shifted value.
  logic [N-1:0]       r_r;
  // The leading divisor coefficient never matters after the XOR, because
  // R'[d] is cleared by construction. Only the low N bits are stored.
  logic [N-1:0]       r_b;
  logic [c_DEG_W-1:0] r_deg;
  logic [c_K_W-1:0]   r_k;
  logic               r_done;
  logic               r_dbz;
  logic [N-1:0]       r_rem;

  logic [c_DEG_W-1:0] w_deg;
  logic               w_zero;
  logic [N:0]         w_r_shift;
  logic               w_qbit;
  logic [N-1:0]       w_r_next;
  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic               w_busy;

  // Degree of the incoming divisor: highest set coefficient, 0 when divisor is 0 or 1.
  always_comb begin
    w_deg = '0;
    for (int i = 0; i <= N; i++) begin
      if (bus.divisor[i]) w_deg = c_DEG_W'(i);
    end
  end

  assign w_zero = (bus.divisor == '0);

  // One long-division step: bring down the next dividend bit and subtract (XOR) B when R'[d] is set.
  always_comb begin
    w_r_shift = {r_r, r_d[2*N-1]};
    w_qbit    = w_r_shift[r_deg];
    w_r_next  = w_r_shift[N-1:0] ^ (r_b & {N{w_qbit}});
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= c_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic: a nonzero divisor starts a division, and the 2N-th step returns to idle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:  if (bus.start && !w_zero) w_state_next = c_DIV;
      c_DIV:   if (r_k == c_K_LAST)      w_state_next = c_IDLE;
      default: w_state_next = c_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_last   = 1'b0;
    w_busy   = 1'b0;
    case (r_state)
      c_IDLE: w_accept = bus.start;
      c_DIV: begin
        w_busy = 1'b1;
        w_step = 1'b1;
        w_last = (r_k == c_K_LAST);
      end
      default: ;
    endcase
  end

  // Datapath: latch operands on accept, run one step per DIV cycle, publish results on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_d    <= '0;
      r_r    <= '0;
      r_b    <= '0;
      r_deg  <= '0;
      r_k    <= '0;
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      r_rem  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_d    <= bus.dividend;
        r_b    <= bus.divisor[N-1:0];
        r_deg  <= w_deg;
        r_r    <= '0;
        r_k    <= '0;
        r_rem  <= '0;
        r_dbz  <= w_zero;
        r_done <= w_zero;
      end else if (w_step) begin
        r_r <= w_r_next;
        r_d <= {r_d[2*N-2:0], w_qbit};
        r_k <= r_k + 1'b1;
        if (w_last) begin
          r_rem  <= w_r_next;
          r_done <= 1'b1;
        end
      end
    end
  end

`ifdef GF2_DIV_QUOTIENT_EN
  logic [2*N-1:0] r_quo;

  // Quotient output: cleared on accept, loaded from D on completion of the last step.
  always_ff @(posedge clk) begin
    if (rst)                 r_quo <= '0;
    else if (w_accept)       r_quo <= '0;
    else if (w_step && w_last) r_quo <= {r_d[2*N-2:0], w_qbit};
  end

  assign bus.quotient = r_quo;
`else
  assign bus.quotient = '0;
`endif

  assign bus.busy        = w_busy;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.remainder   = r_rem;

endmodule
`default_nettype wire

// File: tb/tb_gf2_poly_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gf2_poly_divider
//  Description : Self-checking bench for gf2_poly_divider: directed vector
//                table plus hand-written handshake corner cases and a few
//                random carry-less products.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gf2_poly_divider;

  localparam int N   = 571;
  localparam int LAT = 2 * N;
`ifdef GF2_DIV_QUOTIENT_EN
  localparam bit QEN = 1'b1;
`else
  localparam bit QEN = 1'b0;
`endif

  typedef struct {
    string          name;
    logic [2*N-1:0] dvd;
    logic [N:0]     dvs;
    logic [2*N-1:0] q;
    logic [N-1:0]   r;
    logic           dbz;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  gf2_poly_divider_if #(.N(N)) bus ();

  gf2_poly_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [2*N-1:0] act, input logic [2*N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2*N-1:0] qx(input logic [2*N-1:0] q);
    return q & {(2*N){QEN}};
  endfunction

  // Called at a negedge; returns at the first negedge after the accepting edge.
  task automatic pulse_start(input logic [2*N-1:0] dvd, input logic [N:0] dvs);
    bus.dividend = dvd;
    bus.divisor  = dvs;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  // c counts cycles after the accepting edge (0 = cycle right after it).
  task automatic wait_done(input int exp_lat, input int c0, input string name);
    int c = c0;
    while (bus.done !== 1'b1 && c < exp_lat + 8) begin
      @(negedge clk);
      c++;
    end
    chk({name, " latency"}, c, exp_lat);
    chk({name, " busy at done"}, bus.busy, 1'b0);
  endtask

  task automatic check_res(input string name, input logic [2*N-1:0] q,
                           input logic [N-1:0] r, input logic dbz);
    chk({name, " quotient"}, bus.quotient, qx(q));
    chk({name, " remainder"}, bus.remainder, r);
    chk({name, " div_by_zero"}, bus.div_by_zero, dbz);
  endtask

  function automatic logic [2*N-1:0] clmul(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [2*N-1:0] p  = '0;
    logic [2*N-1:0] aa = {{N{1'b0}}, a};
    for (int i = 0; i < N; i++) if (b[i]) p ^= aa << i;
    return p;
  endfunction

  // Reference long division over the whole vector (divisor assumed nonzero).
  task automatic polydiv(input logic [2*N-1:0] a, input logic [N:0] b,
                         output logic [2*N-1:0] q, output logic [N-1:0] r);
    logic [2*N-1:0] x  = a;
    logic [2*N-1:0] bb = {{(N-1){1'b0}}, b};
    int d = 0;
    for (int i = 0; i <= N; i++) if (b[i]) d = i;
    q = '0;
    for (int i = 2*N-1; i >= d; i--) begin
      if (x[i]) begin
        x ^= bb << (i - d);
        q[i-d] = 1'b1;
      end
    end
    r = x[N-1:0];
  endtask

  function automatic logic [N-1:0] rnd_poly();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  vec_t           tbl[5];
  logic [N:0]     fpoly;
  logic [2*N-1:0] tmp_w;
  logic [N-1:0]   tmp_n;
  logic [N-1:0]   ra, rb;
  logic [2*N-1:0] prod, mq;
  logic [N-1:0]   mr;
  int             seen;

  initial begin
    fpoly = '0;
    fpoly[571] = 1'b1; fpoly[10] = 1'b1; fpoly[5] = 1'b1; fpoly[2] = 1'b1; fpoly[0] = 1'b1;

    tbl[0] = '{name: "x3+1 / x+1", dvd: (2*N)'('h9), dvs: (N+1)'('h3),
               q: (2*N)'('h7), r: N'('h0), dbz: 1'b0};
    tmp_w = '0; tmp_w[1140] = 1'b1;
    tbl[1].name = "x1140 / field"; tbl[1].dvd = tmp_w; tbl[1].dvs = fpoly;
    tmp_w = '0; tmp_w[569] = 1'b1; tmp_w[8] = 1'b1; tmp_w[3] = 1'b1; tmp_w[0] = 1'b1;
    tbl[1].q = tmp_w;
    tmp_n = '0; tmp_n[569] = 1'b1; tmp_n[18] = 1'b1; tmp_n[3] = 1'b1; tmp_n[2] = 1'b1; tmp_n[0] = 1'b1;
    tbl[1].r = tmp_n; tbl[1].dbz = 1'b0;
    tbl[2] = '{name: "zero divisor", dvd: (2*N)'('hDEADBEEF), dvs: '0,
               q: '0, r: '0, dbz: 1'b1};
    tbl[3] = '{name: "divisor one", dvd: (2*N)'('hDEADBEEF), dvs: (N+1)'('h1),
               q: (2*N)'('hDEADBEEF), r: '0, dbz: 1'b0};
    tbl[4] = '{name: "dividend below degree", dvd: (2*N)'('h1234), dvs: fpoly,
               q: '0, r: N'('h1234), dbz: 1'b0};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset div_by_zero", bus.div_by_zero, 1'b0);
    chk("reset quotient", bus.quotient, '0);
    chk("reset remainder", bus.remainder, '0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      pulse_start(tbl[i].dvd, tbl[i].dvs);
      if (!tbl[i].dbz) chk({tbl[i].name, " busy after accept"}, bus.busy, 1'b1);
      wait_done(tbl[i].dbz ? 0 : LAT, 0, tbl[i].name);
      check_res(tbl[i].name, tbl[i].q, tbl[i].r, tbl[i].dbz);
      @(negedge clk);
      chk({tbl[i].name, " done one cycle"}, bus.done, 1'b0);
    end

    // Back-to-back: second start issued in the done cycle of the first.
    pulse_start((2*N)'('hB), (N+1)'('h3));
    wait_done(LAT, 0, "b2b first");
    check_res("b2b first", (2*N)'('h6), N'('h1), 1'b0);
    pulse_start((2*N)'('h9), (N+1)'('h7));
    chk("b2b done falls", bus.done, 1'b0);
    chk("b2b second busy", bus.busy, 1'b1);
    chk("b2b cleared remainder", bus.remainder, '0);
    wait_done(LAT, 0, "b2b second");
    check_res("b2b second", (2*N)'('h3), N'('h0), 1'b0);
    @(negedge clk);

    // Start during a busy division is ignored.
    pulse_start((2*N)'('h9), (N+1)'('h3));
    repeat (5) @(negedge clk);
    chk("ignore busy", bus.busy, 1'b1);
    chk("ignore remainder held", bus.remainder, '0);
    bus.dividend = (2*N)'('hB);
    bus.divisor  = (N+1)'('h1);
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    wait_done(LAT, 6, "ignore");
    check_res("ignore", (2*N)'('h7), N'('h0), 1'b0);
    @(negedge clk);

    // Reset in the middle of a division aborts it without a done pulse.
    pulse_start((2*N)'('hB), (N+1)'('h3));
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy", bus.busy, 1'b0);
    chk("abort done", bus.done, 1'b0);
    check_res("abort", '0, '0, 1'b0);
    rst = 1'b0;
    seen = 0;
    repeat (LAT + 5) begin
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("abort no done", seen, 0);
    pulse_start((2*N)'('h9), (N+1)'('h7));
    wait_done(LAT, 0, "after abort");
    check_res("after abort", (2*N)'('h3), N'('h0), 1'b0);
    @(negedge clk);

    // Random carry-less products: exact division by a factor and reduction by the field polynomial.
    for (int t = 0; t < 4; t++) begin
      ra = rnd_poly();
      rb = rnd_poly() | N'(1);
      prod = clmul(ra, rb);
      pulse_start(prod, {1'b0, rb});
      wait_done(LAT, 0, "rand exact");
      check_res("rand exact", {{N{1'b0}}, ra}, '0, 1'b0);
      @(negedge clk);
      polydiv(prod, fpoly, mq, mr);
      pulse_start(prod, fpoly);
      wait_done(LAT, 0, "rand field");
      check_res("rand field", mq, mr, 1'b0);
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
